puf_request_arbiter: RTL
========================

# puf_request_arbiter

Shares the single PUF evaluation engine (the challenge-driven controller sequencing ring-oscillator reset/select/enable/store) among NUM_REQ independent requesters, e.g. host interface and built-in self-test. Arbitrates round-robin and forwards the winner's challenge with a one-cycle start pulse. It then waits for engine completion, with a timeout, and returns the response to the winner only. Sits between the requester front-ends and the engine's start/challenge/done ports.

## Interface
- NUM_REQ, 2, number of requesters (≥2)
- CHALLENGE_BITS, 4, challenge width per requester
- RESPONSE_BITS, 1, response word width
- TIMEOUT_CYCLES, 4096, max cycles in WAIT before abort (≥2)
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req  in  NUM_REQ  level request per requester; held until its rsp_valid
- req_challenge  in  NUM_REQ*CHALLENGE_BITS  requester i at bits [i*CHALLENGE_BITS +: CHALLENGE_BITS]; stable while req high
- grant  out  NUM_REQ  one-hot owner of current job, else 0
- rsp_valid  out  NUM_REQ  one-cycle pulse to owner when job ends
- rsp_data  out  RESPONSE_BITS  response, valid with rsp_valid
- rsp_error  out  1  timeout flag, valid with rsp_valid
- busy  out  1  high in every state except IDLE
- eng_start  out  1  one-cycle start pulse to engine
- eng_challenge  out  CHALLENGE_BITS  latched challenge, held START..RESPOND
- eng_done  in  1  engine completion (pulse or level)
- eng_response  in  RESPONSE_BITS  sampled in cycle eng_done rise is detected
- eng_abort  out  1  one-cycle pulse on timeout; engine returns to idle

## Operation
- States: IDLE, START, WAIT, ABORT, RESPOND. All outputs registered.
- IDLE: if any req high, pick winner round-robin from pointer ptr (search ptr, ptr+1, … wrapping mod NUM_REQ); latch its challenge into eng_challenge, set grant one-hot, ptr ← winner+1 mod NUM_REQ; → START. No req → stay.
- START: eng_start=1 for exactly this cycle; clear timer; → WAIT.
- WAIT: done_q tracks eng_done previous value. Rising edge (eng_done=1, done_q=0) → latch eng_response, rsp_error←0, → RESPOND. Else timer increments; when timer reaches TIMEOUT_CYCLES−1 with no edge → ABORT. An edge in the same cycle as expiry wins (response, no error).
- eng_done is ignored outside WAIT; done_q updates every cycle, so a done level left high from a prior job produces no edge.
- ABORT: eng_abort=1 one cycle; rsp_data←0, rsp_error←1; → RESPOND.
- RESPOND: rsp_valid[owner]=1 one cycle; grant, eng_challenge held; → IDLE, where grant clears to 0.
- Requester must drop req on the edge after seeing rsp_valid. A req still high in IDLE is a new job.
- Requests arriving or dropping during a job are not aborted. A req dropped by the owner mid-job still completes; the rsp_valid pulse is delivered regardless.
- Timer width $clog2(TIMEOUT_CYCLES); saturates; no wrap.

## Timing
- Reset (async assert, sync release): state IDLE; grant, rsp_valid, rsp_data, rsp_error, busy, eng_start, eng_abort, eng_challenge all 0; ptr=0; timer=0; done_q=0.
- Reset asserted mid-job: immediate return to IDLE, no rsp_valid emitted. The engine shares the system reset.
- req sampled high at edge k → grant, busy, eng_start, eng_challenge valid after edge k.
- Engine done edge sampled at edge m → rsp_valid/rsp_data after edge m, for one cycle.
- Timeout: ABORT entered exactly TIMEOUT_CYCLES cycles after entering WAIT; rsp_valid with error one cycle after eng_abort.
- Back-to-back: minimum 4 cycles per job plus engine latency; IDLE occupies ≥1 cycle between jobs.
- Fairness: with all req permanently high, grants rotate 0,1,…,NUM_REQ−1,0.

## Structure
- Package puf_ctrl_pkg: state enum typedef (IDLE, START, WAIT, ABORT, RESPOND), shared by the engine-side modules.
- Sub-module rr_pick: combinational round-robin picker (req, ptr → one-hot winner + index). Instantiated once; reusable elsewhere.
- Counter, latches and FSM live in puf_request_arbiter.

## Test plan
- Single request: req=2'b01, challenge0=4'hA, engine done 20 cycles after start, response 1 → eng_challenge=4'hA, one eng_start pulse, rsp_valid=2'b01 with rsp_data=1, rsp_error=0.
- Contention: req=2'b11 from reset → grant order 01, 10, 01. Each job's eng_challenge matches its owner's challenge.
- Timeout: TIMEOUT_CYCLES=16, engine never asserts done → eng_abort exactly 16 cycles after entering WAIT, then rsp_valid with rsp_error=1, rsp_data=0.
- Stale done: engine holds eng_done=1 across next start → no early completion; job completes only on a fresh 0→1 edge.
- Done on expiry cycle: edge coincident with timer=TIMEOUT_CYCLES−1 → response returned, rsp_error=0, no eng_abort.
- Reset mid-WAIT: reset low for 2 cycles → all outputs 0 immediately, no rsp_valid; next req=2'b10 granted first (ptr=0, req0 idle).

Source files
------------

// File: rtl/puf_ctrl_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : puf_ctrl_pkg
// Description : Shared types for the PUF engine-side control modules.
//               Holds the request arbiter state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package puf_ctrl_pkg;

    // Arbiter job sequencing states. The 3-bit encoding is fixed so that
    // legacy code can compare against the raw values.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_ABORT   = 3'd3,
        ST_RESPOND = 3'd4
    } puf_state_e;

endpackage : puf_ctrl_pkg
`default_nettype wire

// File: rtl/puf_request_arbiter_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : puf_request_arbiter_if
// Description : Bundle of requester-side and engine-side signals around the
//               PUF request arbiter.
//   req / req_challenge         : level requests and per-requester challenges
//   grant / rsp_valid / rsp_*   : job owner and one-cycle response return
//   busy                        : arbiter not idle
//   eng_start / eng_challenge   : start pulse and challenge towards engine
//   eng_done / eng_response     : engine completion and response word
//   eng_abort                   : one-cycle abort pulse on timeout
// Modports    : master - requesters + engine (drive req/challenge/done)
//               slave  - the arbiter
// Revision    : 1.0 - initial release
// ============================================================================
interface puf_request_arbiter_if #(
    parameter int NUM_REQ        = 2,
    parameter int CHALLENGE_BITS = 4,
    parameter int RESPONSE_BITS  = 1
) ();
    logic [NUM_REQ-1:0]                req;
    logic [NUM_REQ*CHALLENGE_BITS-1:0] req_challenge;
    logic [NUM_REQ-1:0]                grant;
    logic [NUM_REQ-1:0]                rsp_valid;
    logic [RESPONSE_BITS-1:0]          rsp_data;
    logic                              rsp_error;
    logic                              busy;
    logic                              eng_start;
    logic [CHALLENGE_BITS-1:0]         eng_challenge;
    logic                              eng_done;
    logic [RESPONSE_BITS-1:0]          eng_response;
    logic                              eng_abort;

    modport master (
        output req, req_challenge, eng_done, eng_response,
        input  grant, rsp_valid, rsp_data, rsp_error, busy,
               eng_start, eng_challenge, eng_abort
    );

    modport slave (
        input  req, req_challenge, eng_done, eng_response,
        output grant, rsp_valid, rsp_data, rsp_error, busy,
               eng_start, eng_challenge, eng_abort
    );
endinterface : puf_request_arbiter_if
`default_nettype wire

// File: rtl/puf_request_arbiter_rr_pick.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Searches i_req starting at
//               i_ptr and wrapping modulo NUM_REQ; returns the first set bit.
//   i_req   : request vector
//   i_ptr   : index with highest priority this round
//   o_grant : one-hot winner (0 when no request)
//   o_idx   : winner index
//   o_valid : at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  wire logic [NUM_REQ-1:0] i_req,
    input  wire logic [PTR_W-1:0]   i_ptr,
    output logic      [NUM_REQ-1:0] o_grant,
    output logic      [PTR_W-1:0]   o_idx,
    output logic                    o_valid
);
    logic [PTR_W:0] w_cand;

    // Walk the offsets from farthest to nearest so that the candidate closest
    // to i_ptr is the last one written and therefore wins, without a break.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_cand  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_cand = {1'b0, i_ptr} + (PTR_W+1)'(i);
            if (w_cand >= (PTR_W+1)'(NUM_REQ)) begin
                w_cand = w_cand - (PTR_W+1)'(NUM_REQ);
            end
            if (i_req[w_cand[PTR_W-1:0]]) begin
                o_grant                     = '0;
                o_grant[w_cand[PTR_W-1:0]]  = 1'b1;
                o_idx                       = w_cand[PTR_W-1:0];
                o_valid                     = 1'b1;
            end
        end
    end
endmodule : rr_pick
`default_nettype wire

// File: rtl/puf_request_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : puf_request_arbiter
// Description : Shares one PUF evaluation engine among NUM_REQ requesters.
//               Round-robin arbitration, one-cycle engine start pulse, wait
//               for a fresh done edge with timeout/abort, response returned
//               to the job owner only. All outputs are registered.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : requester/engine signal bundle (slave side)
// Revision    : 1.0 - initial release
// ============================================================================
module puf_request_arbiter
    import puf_ctrl_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int CHALLENGE_BITS = 4,
    parameter int RESPONSE_BITS  = 1,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  wire logic           clk,
    input  wire logic           reset,
    puf_request_arbiter_if.slave bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] c_TMR_MAX = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [PTR_W-1:0] c_PTR_LAST = PTR_W'(NUM_REQ - 1);

    puf_state_e                r_state;
    logic [PTR_W-1:0]          r_ptr;
    logic [TMR_W-1:0]          r_timer;
    logic                      r_done_q;
    logic [NUM_REQ-1:0]        r_grant;
    logic [NUM_REQ-1:0]        r_rsp_valid;
    logic [RESPONSE_BITS-1:0]  r_rsp_data;
    logic                      r_rsp_error;
    logic                      r_busy;
    logic                      r_eng_start;
    logic                      r_eng_abort;
    logic [CHALLENGE_BITS-1:0] r_eng_challenge;

    logic [NUM_REQ-1:0]        w_win_grant;
    logic [PTR_W-1:0]          w_win_idx;
    logic                      w_win_valid;
    logic [CHALLENGE_BITS-1:0] w_win_challenge;
    logic [PTR_W-1:0]          w_ptr_next;
    logic                      w_done_rise;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .i_req   (bus.req),
        .i_ptr   (r_ptr),
        .o_grant (w_win_grant),
        .o_idx   (w_win_idx),
        .o_valid (w_win_valid)
    );

    assign w_win_challenge = bus.req_challenge[w_win_idx*CHALLENGE_BITS +: CHALLENGE_BITS];
    assign w_ptr_next      = (w_win_idx == c_PTR_LAST) ? '0 : w_win_idx + PTR_W'(1);

    // r_done_q follows eng_done in every state, so a done level still high
    // from the previous job never looks like a new completion.
    assign w_done_rise = bus.eng_done & ~r_done_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state         <= ST_IDLE;
            r_ptr           <= '0;
            r_timer         <= '0;
            r_done_q        <= 1'b0;
            r_grant         <= '0;
            r_rsp_valid     <= '0;
            r_rsp_data      <= '0;
            r_rsp_error     <= 1'b0;
            r_busy          <= 1'b0;
            r_eng_start     <= 1'b0;
            r_eng_abort     <= 1'b0;
            r_eng_challenge <= '0;
        end else begin
            r_done_q    <= bus.eng_done;
            r_eng_start <= 1'b0;
            r_eng_abort <= 1'b0;
            r_rsp_valid <= '0;

            case (r_state)
                ST_IDLE: begin
                    if (w_win_valid) begin
                        r_grant         <= w_win_grant;
                        r_eng_challenge <= w_win_challenge;
                        r_ptr           <= w_ptr_next;
                        r_eng_start     <= 1'b1;
                        r_busy          <= 1'b1;
                        r_state         <= ST_START;
                    end
                end
                ST_START: begin
                    r_timer <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A completion edge takes priority over timer expiry.
                    if (w_done_rise) begin
                        r_rsp_data  <= bus.eng_response;
                        r_rsp_error <= 1'b0;
                        r_rsp_valid <= r_grant;
                        r_state     <= ST_RESPOND;
                    end else if (r_timer == c_TMR_MAX) begin
                        r_eng_abort <= 1'b1;
                        r_state     <= ST_ABORT;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                ST_ABORT: begin
                    r_rsp_data  <= '0;
                    r_rsp_error <= 1'b1;
                    r_rsp_valid <= r_grant;
                    r_state     <= ST_RESPOND;
                end
                ST_RESPOND: begin
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.grant         = r_grant;
    assign bus.rsp_valid     = r_rsp_valid;
    assign bus.rsp_data      = r_rsp_data;
    assign bus.rsp_error     = r_rsp_error;
    assign bus.busy          = r_busy;
    assign bus.eng_start     = r_eng_start;
    assign bus.eng_challenge = r_eng_challenge;
    assign bus.eng_abort     = r_eng_abort;
endmodule : puf_request_arbiter
`default_nettype wire
